// File: rtl/shifter_pkg.sv
// Shared types for the sequential ARM-style shifter: shift encodings, FSM states
// and the step-count rule that turns a request into a number of 1-bit steps.
package shifter_pkg;

   typedef enum logic [1:0] {
      ShLsl = 2'b00,
      ShLsr = 2'b01,
      ShAsr = 2'b10,
      ShRor = 2'b11
   } shift_t;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_t;

   // Out-of-range LSL/LSR saturate at 33 steps so the carry drains to zero as well.
   function automatic logic [5:0] step_count(input logic       imm_mode,
                                             input logic [3:0] rot,
                                             input shift_t     st,
                                             input logic       rrx,
                                             input logic [7:0] amount);
      logic [5:0] n;
      n = '0;
      if (imm_mode) begin
         n = {1'b0, rot, 1'b0};
      end else begin
         case (st)
            ShLsl, ShLsr: n = (amount > 8'd33) ? 6'd33 : amount[5:0];
            ShAsr:        n = (amount > 8'd32) ? 6'd32 : amount[5:0];
            default: begin
               if (rrx)                     n = 6'd1;
               else if (amount == 8'd0)     n = 6'd0;
               else if (amount[4:0] == '0)  n = 6'd32;
               else                         n = {1'b0, amount[4:0]};
            end
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational 1-bit shift/rotate step with carry-out.
module shift_step
   import shifter_pkg::*;
(
   input  logic [31:0] cur_value,
   input  logic        cur_carry,
   input  shift_t      shift_type,
   input  logic        rrx,
   output logic [31:0] next_value,
   output logic        next_carry
);

   always_comb begin
      next_value = cur_value;
      next_carry = cur_value[0];
      case (shift_type)
         ShLsl: begin
            next_value = {cur_value[30:0], 1'b0};
            next_carry = cur_value[31];
         end
         ShLsr: next_value = {1'b0, cur_value[31:1]};
         ShAsr: next_value = {cur_value[31], cur_value[31:1]};
         ShRor: next_value = {(rrx ? cur_carry : cur_value[0]), cur_value[31:1]};
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential shifter: captures a request, applies one 1-bit step per cycle,
// then pulses done with the result and carry held until the next accepted start.
module shift_sequencer
   import shifter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        imm_mode,
   input  logic [11:0] imm12,
   input  logic [31:0] operand,
   input  logic [1:0]  shift_type,
   input  logic        rrx,
   input  logic [7:0]  amount,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        carry_out
);

   state_t      state;
   logic [31:0] work;
   logic        carry_reg;
   logic [5:0]  count;
   shift_t      op_type;
   logic        op_rrx;
   logic [31:0] step_value;
   logic        step_carry;

   shift_step u_step (
      .cur_value  (work),
      .cur_carry  (carry_reg),
      .shift_type (op_type),
      .rrx        (op_rrx),
      .next_value (step_value),
      .next_carry (step_carry)
   );

   assign result    = work;
   assign carry_out = carry_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         work      <= '0;
         carry_reg <= 1'b0;
         count     <= '0;
         op_type   <= ShLsl;
         op_rrx    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  work      <= imm_mode ? {24'b0, imm12[7:0]} : operand;
                  carry_reg <= carry_in;
                  count     <= step_count(imm_mode, imm12[11:8], shift_t'(shift_type), rrx,
                                          amount);
                  // Immediates are plain rotates; RRX only exists on the ROR encoding.
                  op_type   <= imm_mode ? ShRor : shift_t'(shift_type);
                  op_rrx    <= ~imm_mode & rrx & (shift_type == ShRor);
                  busy      <= 1'b1;
                  state     <= StShift;
               end else begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            StShift: begin
               if (count == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  work      <= step_value;
                  carry_reg <= step_carry;
                  count     <= count - 6'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request strobe; sampled on a rising edge while busy=0.
REQ-005 imm_mode  input  1  1 = ARM rotated immediate (imm12); 0 = shift operand.
REQ-006 imm12  input  12  [11:8] rotate field, [7:0] imm8; used when imm_mode=1.
REQ-007 operand  input  32  value to shift; used when imm_mode=0.
REQ-008 shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; used when imm_mode=0.
REQ-009 rrx  input  1  with shift_type=11 and imm_mode=0, selects RRX; amount is ignored.
REQ-010 amount  input  8  resolved shift amount, 0..255.
REQ-011 carry_in  input  1  current C flag.
REQ-012 busy  output  1  request in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  32  shifted or rotated value.
REQ-015 carry_out  output  1  shifter carry-out.

Function
REQ-016 States SHALL be IDLE, SHIFT and DONE.
REQ-017 start=1 with busy=0 SHALL capture all inputs on that edge; start while busy=1 SHALL be ignored with no effect.
REQ-018 On capture, the working register SHALL load operand, or {24'b0, imm8} when imm_mode=1; the carry register SHALL load carry_in.
REQ-019 The step count E SHALL be set as follows:
- imm_mode=1: 2*imm12[11:8]
- RRX: 1
- LSL or LSR: min(amount, 33)
- ASR: min(amount, 32)
- ROR with amount=0: 0
- ROR with amount[4:0]=0 and amount!=0: 32
- ROR otherwise: amount[4:0]
REQ-020 Each SHIFT cycle SHALL perform exactly one 1-bit step and decrement the remaining count.
- LSL: shift left, 0 in; carry = old bit31.
- LSR: shift right, 0 in; carry = old bit0.
- ASR: shift right, old bit31 in; carry = old bit0.
- ROR and immediate: rotate right; carry = old bit0.
- RRX: shift right with the carry register into bit31; carry = old bit0.
REQ-021 With E=0, the FSM SHALL go directly to DONE on the edge after capture: result = loaded value, carry_out = carry_in.
REQ-022 busy SHALL be 1 from the capture edge until the edge on which done rises.
REQ-023 done SHALL be 1 for exactly the cycle following the E+1th rising edge after the capture edge (latency E+1 cycles).
REQ-024 result and carry_out SHALL be valid while done=1 and SHALL hold until the next accepted start.
REQ-025 start during the DONE cycle SHALL be accepted (busy=0 there), allowing back-to-back requests with no idle cycle.
REQ-026 During SHIFT, result SHALL show the working register, with no validity implied.

Reset
REQ-027 rst=1 SHALL immediately force IDLE with busy=0, done=0, result=0, carry_out=0 and count=0, including mid-operation; the in-flight request is discarded.
REQ-028 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-029 Shift-type encodings (LSL/LSR/ASR/ROR) and the state enumeration SHALL live in a shared package, shifter_pkg.
REQ-030 The single-bit step logic SHALL be a combinational sub-module, shift_step, with inputs value, carry and type/rrx, and outputs value and carry.
REQ-031 The step counter SHALL be 6 bits wide; no 32-bit barrel shifter is permitted.

Verification
REQ-032 imm_mode=1, imm12=0x4FF, carry_in=0 -> done after 9 cycles; result=0xFF000000, carry_out=1.
REQ-033 LSL, operand=0x00000001, amount=32, carry_in=0 -> result=0, carry_out=1, latency 33; same request with amount=200 -> result=0, carry_out=0, latency 34.
REQ-034 ASR, operand=0x80000000, amount=40 -> result=0xFFFFFFFF, carry_out=1, latency 33.
REQ-035 RRX, operand=0x00000003, carry_in=1 -> result=0x80000001, carry_out=1, latency 2; ROR with amount=0, carry_in=1 -> result=operand, carry_out=1, latency 1.
REQ-036 Assert rst for one cycle, asynchronously, in the middle of an LSR #20 -> outputs zero immediately; a new request then completes correctly. A start during busy is ignored, and a start during the done cycle is accepted.
